// File: rtl/regfile_mp.sv
// Multi-port general register file: NREAD combinational reads, two write ports,
// x0 hardwired to zero, same-cycle write bypass, per-register pending bits and a post-reset clear sequencer.
module regfile_mp #(
  parameter int WORD      = 32,
  parameter int REG_COUNT = 32,
  parameter int REG_SIZE  = 5,
  parameter int NREAD     = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic                      ready,
  input  logic [NREAD*REG_SIZE-1:0] raddr,
  output logic [NREAD*WORD-1:0]     rdata,
  output logic [NREAD-1:0]          rbusy,
  input  logic                      we0,
  input  logic [REG_SIZE-1:0]       waddr0,
  input  logic [WORD-1:0]           wdata0,
  input  logic                      we1,
  input  logic [REG_SIZE-1:0]       waddr1,
  input  logic [WORD-1:0]           wdata1,
  input  logic                      iss_valid,
  input  logic [REG_SIZE-1:0]       iss_addr
);

  typedef enum logic {CLEAR, RUN} state_t;

  localparam logic [REG_SIZE-1:0] LAST = REG_SIZE'(REG_COUNT - 1);

  state_t                state, state_next;
  logic [REG_SIZE-1:0]   cnt;
  logic [WORD-1:0]       grf [REG_COUNT];
  logic [REG_COUNT-1:0]  pend, pend_next;
  logic                  active, wen0, wen1;

  // Traffic is accepted only in RUN and never in a cycle where reset is asserted.
  assign active = (state == RUN) && !rst;
  assign wen0   = active && we0 && (waddr0 != '0);
  assign wen1   = active && we1 && (waddr1 != '0);
  assign ready  = (state == RUN);

  always_ff @(posedge clk) begin
    if (rst) state <= CLEAR;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      CLEAR:   if (cnt == LAST) state_next = RUN;
      RUN:     state_next = RUN;
      default: state_next = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)                 cnt <= REG_SIZE'(1);
    else if (state == CLEAR) cnt <= cnt + REG_SIZE'(1);
  end

  // Port 1 is written last so it wins a same-address conflict.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR) begin
        grf[cnt] <= '0;
      end else begin
        if (wen0) grf[waddr0] <= wdata0;
        if (wen1) grf[waddr1] <= wdata1;
      end
    end
  end

  // A new issue sets after the retiring writes clear, since the issuing writer is younger.
  always_comb begin
    pend_next = pend;
    if (wen0) pend_next[waddr0] = 1'b0;
    if (wen1) pend_next[waddr1] = 1'b0;
    if (active && iss_valid && (iss_addr != '0)) pend_next[iss_addr] = 1'b1;
    pend_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) pend <= '0;
    else     pend <= pend_next;
  end

  for (genvar i = 0; i < NREAD; i++) begin : g_read
    logic [REG_SIZE-1:0] a;
    logic                hit0, hit1;

    assign a    = raddr[i*REG_SIZE +: REG_SIZE];
    assign hit1 = wen1 && (waddr1 == a);
    assign hit0 = wen0 && (waddr0 == a);

    assign rdata[i*WORD +: WORD] = (!active || (a == '0)) ? '0     :
                                   hit1                   ? wdata1 :
                                   hit0                   ? wdata0 :
                                                            grf[a];
    assign rbusy[i] = active && pend[a] && !hit0 && !hit1;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Randomized bench for regfile_mp: directed scenarios plus random traffic,
// all checked against an array-based reference model of the register file.
module tb_regfile_mp;

  localparam int WORD = 32, REG_COUNT = 32, REG_SIZE = 5, NREAD = 2;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      ready;
  logic [NREAD*REG_SIZE-1:0] raddr;
  logic [NREAD*WORD-1:0]     rdata;
  logic [NREAD-1:0]          rbusy;
  logic                      we0, we1, iss_valid;
  logic [REG_SIZE-1:0]       waddr0, waddr1, iss_addr;
  logic [WORD-1:0]           wdata0, wdata1;

  logic [WORD-1:0] m_grf [REG_COUNT];
  bit              m_pend [REG_COUNT];
  bit              m_run;
  int              m_idx;
  int              vectors = 0;
  int              miscompares = 0;

  regfile_mp #(.WORD(WORD), .REG_COUNT(REG_COUNT), .REG_SIZE(REG_SIZE), .NREAD(NREAD)) dut (
    .clk(clk), .rst(rst), .ready(ready),
    .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .iss_valid(iss_valid), .iss_addr(iss_addr)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic w0, input logic [4:0] a0, input logic [31:0] d0,
                               input logic w1, input logic [4:0] a1, input logic [31:0] d1,
                               input logic iv, input logic [4:0] ia, input logic [4:0] ra0, input logic [4:0] ra1);
    rst = r; we0 = w0; waddr0 = a0; wdata0 = d0; we1 = w1; waddr1 = a1; wdata1 = d1;
    iss_valid = iv; iss_addr = ia; raddr = {ra1, ra0};
  endtask

  // Reference read: x0 is zero, a same-cycle write forwards (port 1 first), else the stored word.
  task automatic compute_expected(output logic [63:0] d, output logic [1:0] b);
    logic [4:0] a;
    bit live;
    live = m_run && !rst;
    d = '0;
    b = '0;
    for (int p = 0; p < NREAD; p++) begin
      a = raddr[p*REG_SIZE +: REG_SIZE];
      if (live && a != 0) begin
        if (we1 && waddr1 == a)      d[p*WORD +: WORD] = wdata1;
        else if (we0 && waddr0 == a) d[p*WORD +: WORD] = wdata0;
        else begin
          d[p*WORD +: WORD] = m_grf[a];
          b[p] = m_pend[a];
        end
      end
    end
  endtask

  task automatic update_model();
    if (rst) begin
      m_run = 0;
      m_idx = 1;
      for (int k = 0; k < REG_COUNT; k++) m_pend[k] = 0;
    end else if (!m_run) begin
      m_grf[m_idx] = '0;
      m_idx++;
      if (m_idx == REG_COUNT) m_run = 1;
    end else begin
      if (we0 && waddr0 != 0) begin m_grf[waddr0] = wdata0; m_pend[waddr0] = 0; end
      if (we1 && waddr1 != 0) begin m_grf[waddr1] = wdata1; m_pend[waddr1] = 0; end
      if (iss_valid && iss_addr != 0) m_pend[iss_addr] = 1;
    end
  endtask

  task automatic tick();
    logic [63:0] ed;
    logic [1:0]  eb;
    @(negedge clk);
    compute_expected(ed, eb);
    checkOutput("ready", ready, m_run);
    checkOutput("rdata", rdata, ed);
    checkOutput("rbusy", rbusy, eb);
    @(posedge clk);
    update_model();
    #1;
  endtask

  task automatic idle(input logic [4:0] ra0, input logic [4:0] ra1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, ra0, ra1);
  endtask

  task automatic wait_ready(input string tag, output int n);
    n = 0;
    while (!ready && n < 100) begin
      tick();
      n++;
    end
    if (!ready) checkOutput({tag, "_timeout"}, ready, 1);
  endtask

  initial begin
    int n;
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    update_model();
    #1;
    for (int i = 0; i < 3; i++) tick();

    // Clear sequence: ready after exactly 31 edges, every register reads zero.
    idle(0, 0);
    wait_ready("clear", n);
    checkOutput("clear_edges", n, 31);
    for (int r = 0; r < REG_COUNT; r += 2) begin
      idle(r[4:0], 5'(r + 1));
      #1;
      checkOutput("clear_rd", rdata, 0);
      checkOutput("clear_busy", rbusy, 0);
      tick();
    end

    // Write r5 and discarded write to r0.
    applyStimulus(0, 1, 5, 32'hDEADBEEF, 1, 0, 32'h1234, 0, 0, 0, 0);
    tick();
    idle(5, 0);
    #1;
    checkOutput("r5", rdata[31:0], 32'hDEADBEEF);
    checkOutput("r0", rdata[63:32], 0);
    tick();

    // Dual write to r7: port 1 wins, both bypassed and stored.
    applyStimulus(0, 1, 7, 32'h1111, 1, 7, 32'h2222, 0, 0, 7, 0);
    #1;
    checkOutput("r7_bypass", rdata[31:0], 32'h2222);
    tick();
    idle(7, 0);
    #1;
    checkOutput("r7_stored", rdata[31:0], 32'h2222);
    tick();

    // Scoreboard set by issue, cleared by write with bypass.
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 9, 9, 0);
    #1;
    checkOutput("r9_busy_same", rbusy[0], 0);
    tick();
    idle(9, 0);
    #1;
    checkOutput("r9_busy", rbusy[0], 1);
    tick();
    applyStimulus(0, 1, 9, 32'h55, 0, 0, 0, 0, 0, 9, 0);
    #1;
    checkOutput("r9_wr_busy", rbusy[0], 0);
    checkOutput("r9_wr_data", rdata[31:0], 32'h55);
    tick();
    idle(9, 0);
    #1;
    checkOutput("r9_after", rbusy[0], 0);
    tick();

    // Set and clear of r3 in one cycle: set wins.
    applyStimulus(0, 1, 3, 32'hAA, 0, 0, 0, 1, 3, 0, 0);
    tick();
    idle(3, 0);
    #1;
    checkOutput("r3_busy", rbusy[0], 1);
    checkOutput("r3_data", rdata[31:0], 32'hAA);
    tick();

    // Reset in RUN discards state; traffic during clear is ignored.
    applyStimulus(0, 1, 4, 32'h77, 0, 0, 0, 0, 0, 4, 6);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 6, 4, 6);
    tick();
    applyStimulus(1, 1, 4, 32'h99, 0, 0, 0, 1, 6, 4, 6);
    tick();
    checkOutput("rst_ready", ready, 0);
    applyStimulus(0, 1, 4, 32'h99, 1, 6, 32'h66, 1, 6, 4, 6);
    wait_ready("reclear", n);
    checkOutput("reclear_edges", n, 31);
    idle(4, 6);
    #1;
    checkOutput("r4_cleared", rdata, 0);
    checkOutput("r6_idle", rbusy, 0);
    tick();

    // Random traffic over a narrow address window to provoke conflicts.
    for (int i = 0; i < 600; i++) begin
      applyStimulus(($urandom_range(0, 149) == 0),
                    1'($urandom), 5'($urandom_range(0, 11)), $urandom,
                    1'($urandom), 5'($urandom_range(0, 11)), $urandom,
                    1'($urandom), 5'($urandom_range(0, 11)),
                    5'($urandom_range(0, 11)), 5'($urandom_range(0, 11)));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
